// File: rtl/pe_array_feeder.sv
// pe_array_feeder
//
// Drives the operand/control side of the 64-PE dot-product array. It pulls
// act/weight beats from an upstream buffer, groups them into accumulations of
// i_Len beats (o_Sel_Bias marks the first beat of each group) and, after
// i_Groups groups, waits for the array pipeline to drain before pulsing
// o_Job_Done.
//
// Ports
//   CLK, RST             clock, asynchronous active-low reset
//   i_Start / i_Abort    job start (honoured in IDLE only) / abort
//   i_Precision, i_Bias  job precision code and bias, captured at start
//   i_Len, i_Groups      beats per group, groups per job (both must be != 0)
//   s_valid/s_ready      upstream beat handshake; s_act/s_wgt beat payload
//   o_Act ... o_core_vld array operand/control outputs
//   o_Busy               job in progress (LOAD, STREAM, DRAIN, DONE)
//   o_Job_Done / o_Err   one-cycle completion / start-rejected pulses
//   o_State              debug view of the sequencer state
//
// Handshake: a beat transfers on every rising CLK where s_valid && s_ready.
// s_ready depends only on the state register (high in STREAM), so it never
// combinationally depends on s_valid; upstream may hold s_valid high freely.
//
// Optional feature: define FEEDER_PERF_CNT_EN to add o_Stall_Cnt (STREAM
// cycles without a beat) and o_Beat_Cnt (accepted beats). Both clear at LOAD,
// saturate at 16'hFFFF and hold after the job ends.

module pe_array_feeder #(
    parameter int W_ACT    = 64,
    parameter int W_WGT    = 64,
    parameter int N_BIAS   = 16,
    parameter int CNT_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_Start,
    input  logic              i_Abort,
    input  logic [3:0]        i_Precision,
    input  logic [N_BIAS-1:0] i_Bias,
    input  logic [CNT_W-1:0]  i_Len,
    input  logic [CNT_W-1:0]  i_Groups,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W_ACT-1:0]  s_act,
    input  logic [W_WGT-1:0]  s_wgt,
    output logic [W_ACT-1:0]  o_Act,
    output logic [W_WGT-1:0]  o_Weight,
    output logic [3:0]        o_Precision,
    output logic [N_BIAS-1:0] o_Bias,
    output logic              o_Sel_Bias,
    output logic              o_Flush,
    output logic              o_core_vld,
    output logic              o_Busy,
    output logic              o_Job_Done,
    output logic              o_Err,
`ifdef FEEDER_PERF_CNT_EN
    output logic [15:0]       o_Stall_Cnt,
    output logic [15:0]       o_Beat_Cnt,
`endif
    output logic [2:0]        o_State
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // DRAIN covers the cycle the last beat sits on the array inputs plus
    // PIPE_LAT pipeline cycles, so the counter runs 0..PIPE_LAT.
    localparam int               DRN_W    = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT);

    state_t             state_q, state_d;
    logic [3:0]         prec_q, prec_d;
    logic [N_BIAS-1:0]  bias_q, bias_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   groups_q, groups_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   grp_cnt_q, grp_cnt_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [W_ACT-1:0]   act_q, act_d;
    logic [W_WGT-1:0]   wgt_q, wgt_d;
    logic               vld_q, vld_d;
    logic               sel_q, sel_d;
    logic               flush_q, flush_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic accept, start_ok, abort_job, last_beat, last_grp, load_go;

    assign accept    = s_valid & s_ready;
    assign start_ok  = i_Start && (i_Len != '0) && (i_Groups != '0);
    assign abort_job = i_Abort && (state_q != S_IDLE);
    assign last_beat = (beat_cnt_q == len_q - CNT_W'(1));
    assign last_grp  = (grp_cnt_q == groups_q - CNT_W'(1));
    assign load_go   = (state_q == S_IDLE) && (state_d == S_LOAD);

    // Next-state logic. Abort overrides every transition out of a busy state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_ok && !i_Abort) state_d = S_LOAD;
            S_LOAD:   state_d = S_STREAM;
            S_STREAM: if (accept && last_beat && last_grp) state_d = S_DRAIN;
            S_DRAIN:  if (drain_cnt_q == DRN_LAST) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort_job) state_d = S_IDLE;
    end

    // Datapath / registered outputs. Pulses default low every cycle; operand
    // registers hold unless a beat is accepted.
    always_comb begin
        prec_d      = prec_q;
        bias_d      = bias_q;
        len_d       = len_q;
        groups_d    = groups_q;
        beat_cnt_d  = beat_cnt_q;
        grp_cnt_d   = grp_cnt_q;
        drain_cnt_d = drain_cnt_q;
        act_d       = act_q;
        wgt_d       = wgt_q;
        vld_d       = 1'b0;
        sel_d       = 1'b0;
        flush_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        if (abort_job) begin
            flush_d     = 1'b1;
            beat_cnt_d  = '0;
            grp_cnt_d   = '0;
            drain_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Abort in IDLE silently drops a simultaneous start.
                    if (!i_Abort) begin
                        if (start_ok) begin
                            prec_d      = i_Precision;
                            bias_d      = i_Bias;
                            len_d       = i_Len;
                            groups_d    = i_Groups;
                            beat_cnt_d  = '0;
                            grp_cnt_d   = '0;
                            drain_cnt_d = '0;
                            flush_d     = 1'b1;  // high during the LOAD cycle
                        end else if (i_Start) begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        vld_d = 1'b1;
                        sel_d = (beat_cnt_q == '0);
                        act_d = s_act;
                        wgt_d = s_wgt;
                        if (last_beat) begin
                            beat_cnt_d = '0;
                            grp_cnt_d  = last_grp ? '0 : grp_cnt_q + CNT_W'(1);
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                    if (drain_cnt_q == DRN_LAST) begin
                        drain_cnt_d = '0;
                        done_d      = 1'b1;  // high during the DONE cycle
                    end
                end
                default: ;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        s_ready = (state_q == S_STREAM);
        o_Busy  = (state_q != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            prec_q      <= '0;
            bias_q      <= '0;
            len_q       <= '0;
            groups_q    <= '0;
            beat_cnt_q  <= '0;
            grp_cnt_q   <= '0;
            drain_cnt_q <= '0;
            act_q       <= '0;
            wgt_q       <= '0;
            vld_q       <= 1'b0;
            sel_q       <= 1'b0;
            flush_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prec_q      <= prec_d;
            bias_q      <= bias_d;
            len_q       <= len_d;
            groups_q    <= groups_d;
            beat_cnt_q  <= beat_cnt_d;
            grp_cnt_q   <= grp_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            act_q       <= act_d;
            wgt_q       <= wgt_d;
            vld_q       <= vld_d;
            sel_q       <= sel_d;
            flush_q     <= flush_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign o_Act       = act_q;
    assign o_Weight    = wgt_q;
    assign o_Precision = prec_q;
    assign o_Bias      = bias_q;
    assign o_Sel_Bias  = sel_q;
    assign o_Flush     = flush_q;
    assign o_core_vld  = vld_q;
    assign o_Job_Done  = done_q;
    assign o_Err       = err_q;
    assign o_State     = state_q;

`ifdef FEEDER_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] pbeat_cnt_q, pbeat_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        pbeat_cnt_d = pbeat_cnt_q;
        if (load_go) begin
            stall_cnt_d = '0;
            pbeat_cnt_d = '0;
        end else if (state_q == S_STREAM) begin
            if (accept) begin
                if (pbeat_cnt_q != 16'hFFFF) pbeat_cnt_d = pbeat_cnt_q + 16'd1;
            end else begin
                if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt_q <= '0;
            pbeat_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            pbeat_cnt_q <= pbeat_cnt_d;
        end
    end

    assign o_Stall_Cnt = stall_cnt_q;
    assign o_Beat_Cnt  = pbeat_cnt_q;
`endif

endmodule

// File: tb/tb_pe_array_feeder.sv
// Self-checking bench for pe_array_feeder. Inputs are driven on the falling
// edge and outputs sampled on the falling edge, half a period away from the
// active rising edge. Expected beats come from a queue filled as the bench
// itself offers beats while the job is in its streaming phase; group starts
// follow from the running beat index modulo the group length.

module tb_pe_array_feeder;

    localparam int W_ACT    = 64;
    localparam int W_WGT    = 64;
    localparam int N_BIAS   = 16;
    localparam int CNT_W    = 8;
    localparam int PIPE_LAT = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic              i_Start, i_Abort;
    logic [3:0]        i_Precision;
    logic [N_BIAS-1:0] i_Bias;
    logic [CNT_W-1:0]  i_Len, i_Groups;
    logic              s_valid, s_ready;
    logic [W_ACT-1:0]  s_act, o_Act;
    logic [W_WGT-1:0]  s_wgt, o_Weight;
    logic [3:0]        o_Precision;
    logic [N_BIAS-1:0] o_Bias;
    logic              o_Sel_Bias, o_Flush, o_core_vld, o_Busy, o_Job_Done, o_Err;
    logic [2:0]        o_State;
`ifdef FEEDER_PERF_CNT_EN
    logic [15:0]       o_Stall_Cnt, o_Beat_Cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // {sel, wgt, act} per expected beat
    logic [128:0] exp_q[$];
    logic [63:0]  hold_act, hold_wgt;
    logic         hold_known;

    pe_array_feeder #(
        .W_ACT(W_ACT), .W_WGT(W_WGT), .N_BIAS(N_BIAS), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .i_Start(i_Start), .i_Abort(i_Abort),
        .i_Precision(i_Precision), .i_Bias(i_Bias),
        .i_Len(i_Len), .i_Groups(i_Groups),
        .s_valid(s_valid), .s_ready(s_ready), .s_act(s_act), .s_wgt(s_wgt),
        .o_Act(o_Act), .o_Weight(o_Weight), .o_Precision(o_Precision), .o_Bias(o_Bias),
        .o_Sel_Bias(o_Sel_Bias), .o_Flush(o_Flush), .o_core_vld(o_core_vld),
        .o_Busy(o_Busy), .o_Job_Done(o_Job_Done), .o_Err(o_Err),
`ifdef FEEDER_PERF_CNT_EN
        .o_Stall_Cnt(o_Stall_Cnt), .o_Beat_Cnt(o_Beat_Cnt),
`endif
        .o_State(o_State)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Compare the array-side beat outputs against the beat the model says was
    // accepted on the previous edge (or against the held value if none was).
    task automatic check_beat(input logic acc);
        logic [128:0] e;
        check_b("core_vld", o_core_vld, acc);
        if (acc) begin
            e = exp_q.pop_front();
            check("act", o_Act, e[63:0]);
            check("wgt", o_Weight, e[127:64]);
            check_b("sel_bias", o_Sel_Bias, e[128]);
            hold_act   = e[63:0];
            hold_wgt   = e[127:64];
            hold_known = 1'b1;
        end else begin
            check_b("sel_bias_gap", o_Sel_Bias, 1'b0);
            if (hold_known) begin
                check("act_hold", o_Act, hold_act);
                check("wgt_hold", o_Weight, hold_wgt);
            end
        end
    endtask

    // One job. mode 0: s_valid always high, 1: high every other STREAM cycle,
    // 2: random. abort_beat / reset_beat (non-zero) interrupt the job on that
    // accepted beat.
    task automatic run_job(input int len, input int groups, input logic [3:0] prec,
                           input logic [15:0] bias, input int mode,
                           input int abort_beat, input int reset_beat);
        int   total, accepted, stalls, cyc;
        logic prev_acc;
        total    = len * groups;
        accepted = 0;
        stalls   = 0;
        cyc      = 0;
        prev_acc = 1'b0;
        exp_q.delete();

        i_Len       = CNT_W'(len);
        i_Groups    = CNT_W'(groups);
        i_Precision = prec;
        i_Bias      = bias;
        i_Start     = 1'b1;
        s_valid     = 1'b0;
        @(negedge CLK);
        // LOAD cycle
        check_b("load_flush", o_Flush, 1'b1);
        check_b("load_busy", o_Busy, 1'b1);
        check_b("load_ready", s_ready, 1'b0);
        check_b("load_vld", o_core_vld, 1'b0);
        check("load_prec", 64'(o_Precision), 64'(prec));
        check("load_bias", 64'(o_Bias), 64'(bias));
        i_Start  = 1'b0;
        i_Len    = CNT_W'($urandom);  // later changes must not matter
        i_Groups = CNT_W'($urandom);
        s_valid  = 1'b1;              // offered during LOAD, must not be taken
        s_act    = rand64();
        s_wgt    = rand64();

        while (accepted < total) begin
            @(negedge CLK);
            cyc++;
            check_b("stream_ready", s_ready, 1'b1);
            check_b("stream_busy", o_Busy, 1'b1);
            check_b("stream_flush", o_Flush, 1'b0);
            check_b("stream_err", o_Err, 1'b0);
            check_b("stream_done", o_Job_Done, 1'b0);
            check("stream_prec", 64'(o_Precision), 64'(prec));
            check("stream_bias", 64'(o_Bias), 64'(bias));
            check_beat(prev_acc);
            if (cyc > 5000) begin
                n_checks++;
                n_fail++;
                $error("FAIL stream_timeout: observed %0d beats expected %0d", accepted, total);
                return;
            end
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = ((cyc % 2) == 1);
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            s_act   = rand64();
            s_wgt   = rand64();
            i_Start = 1'($urandom_range(0, 1));  // ignored while busy, never an error
            i_Len   = '0;
            prev_acc = s_valid;
            if (s_valid) begin
                exp_q.push_back({((accepted % len) == 0), s_wgt, s_act});
                accepted++;
            end else begin
                stalls++;
            end

            if (abort_beat != 0 && s_valid && accepted == abort_beat) begin
                i_Abort = 1'b1;
                @(negedge CLK);
                i_Abort = 1'b0;
                i_Start = 1'b0;
                s_valid = 1'b0;
                check_b("abort_flush", o_Flush, 1'b1);
                check_b("abort_vld", o_core_vld, 1'b0);
                check_b("abort_sel", o_Sel_Bias, 1'b0);
                check_b("abort_busy", o_Busy, 1'b0);
                check_b("abort_ready", s_ready, 1'b0);
                check_b("abort_done", o_Job_Done, 1'b0);
                exp_q.delete();
                hold_known = 1'b0;
                repeat (PIPE_LAT + 3) begin
                    @(negedge CLK);
                    check_b("post_abort_busy", o_Busy, 1'b0);
                    check_b("post_abort_done", o_Job_Done, 1'b0);
                    check_b("post_abort_flush", o_Flush, 1'b0);
                end
                return;
            end

            if (reset_beat != 0 && accepted == reset_beat) begin
                #2 RST = 1'b0;
                #1;
                check("rst_act", o_Act, 64'h0);
                check("rst_wgt", o_Weight, 64'h0);
                check("rst_prec", 64'(o_Precision), 64'h0);
                check("rst_bias", 64'(o_Bias), 64'h0);
                check_b("rst_sel", o_Sel_Bias, 1'b0);
                check_b("rst_flush", o_Flush, 1'b0);
                check_b("rst_vld", o_core_vld, 1'b0);
                check_b("rst_busy", o_Busy, 1'b0);
                check_b("rst_done", o_Job_Done, 1'b0);
                check_b("rst_err", o_Err, 1'b0);
                check_b("rst_ready", s_ready, 1'b0);
                @(negedge CLK);
                i_Start = 1'b0;
                s_valid = 1'b0;
                RST     = 1'b1;
                exp_q.delete();
                hold_act   = '0;
                hold_wgt   = '0;
                hold_known = 1'b1;
                @(negedge CLK);
                check_b("post_rst_busy", o_Busy, 1'b0);
                check_b("post_rst_done", o_Job_Done, 1'b0);
                return;
            end
        end

        // Last beat accepted: ready drops at once, done follows the drain.
        for (int c = 0; c < PIPE_LAT + 2; c++) begin
            @(negedge CLK);
            check_b("drain_ready", s_ready, 1'b0);
            check_b("drain_busy", o_Busy, 1'b1);
            check_b("drain_flush", o_Flush, 1'b0);
            check_b("drain_err", o_Err, 1'b0);
            check("drain_prec", 64'(o_Precision), 64'(prec));
            check_beat(prev_acc);
            prev_acc = 1'b0;
            check_b("job_done", o_Job_Done, (c == PIPE_LAT + 1));
            s_valid = 1'($urandom_range(0, 1));
            s_act   = rand64();
            s_wgt   = rand64();
            i_Start = (c == PIPE_LAT + 1) ? 1'b0 : 1'($urandom_range(0, 1));
            i_Len   = '0;
        end
        @(negedge CLK);
        check_b("idle_busy", o_Busy, 1'b0);
        check_b("idle_done", o_Job_Done, 1'b0);
        check_b("idle_vld", o_core_vld, 1'b0);
        check_b("idle_err", o_Err, 1'b0);
        check("beats_left", 64'(exp_q.size()), 64'h0);
`ifdef FEEDER_PERF_CNT_EN
        check("stall_cnt", 64'(o_Stall_Cnt), 64'(stalls));
        check("beat_cnt", 64'(o_Beat_Cnt), 64'(total));
`endif
        s_valid = 1'b0;
    endtask

    initial begin
        RST         = 1'b0;
        i_Start     = 1'b0;
        i_Abort     = 1'b0;
        i_Precision = '0;
        i_Bias      = '0;
        i_Len       = '0;
        i_Groups    = '0;
        s_valid     = 1'b0;
        s_act       = '0;
        s_wgt       = '0;
        hold_act    = '0;
        hold_wgt    = '0;
        hold_known  = 1'b1;

        repeat (3) @(negedge CLK);
        check("reset_act", o_Act, 64'h0);
        check("reset_prec", 64'(o_Precision), 64'h0);
        check_b("reset_busy", o_Busy, 1'b0);
        check_b("reset_vld", o_core_vld, 1'b0);
        check_b("reset_flush", o_Flush, 1'b0);
        check_b("reset_ready", s_ready, 1'b0);
        RST = 1'b1;
        @(negedge CLK);

        // Start with a zero length, then with zero groups: error pulse only.
        for (int k = 0; k < 2; k++) begin
            i_Len    = (k == 0) ? 8'd0 : 8'd3;
            i_Groups = (k == 0) ? 8'd2 : 8'd0;
            i_Start  = 1'b1;
            @(negedge CLK);
            i_Start = 1'b0;
            check_b("err_pulse", o_Err, 1'b1);
            check_b("err_busy", o_Busy, 1'b0);
            check_b("err_flush", o_Flush, 1'b0);
            @(negedge CLK);
            check_b("err_clear", o_Err, 1'b0);
            check_b("err_busy2", o_Busy, 1'b0);
        end

        // Abort together with a valid start in IDLE: nothing happens.
        i_Len    = 8'd4;
        i_Groups = 8'd1;
        i_Start  = 1'b1;
        i_Abort  = 1'b1;
        @(negedge CLK);
        i_Start = 1'b0;
        i_Abort = 1'b0;
        check_b("abort_start_busy", o_Busy, 1'b0);
        check_b("abort_start_flush", o_Flush, 1'b0);
        check_b("abort_start_err", o_Err, 1'b0);

        run_job(4, 2, 4'b0101, 16'sd5, 0, 0, 0);   // back-to-back beats
        run_job(4, 2, 4'b0101, 16'sd5, 1, 0, 0);   // valid every other cycle
        run_job(1, 3, 4'b0011, 16'h8001, 0, 0, 0); // every beat starts a group
        run_job(8, 1, 4'b1010, 16'h1234, 0, 3, 0); // abort on the 3rd beat
        run_job(3, 2, 4'b0110, 16'h00ff, 2, 0, 0); // runs normally after abort
        run_job(4, 3, 4'b1111, 16'hbeef, 2, 0, 5); // reset mid-stream
        run_job(4, 2, 4'b0001, 16'h0042, 2, 0, 0); // runs normally after reset
        for (int j = 0; j < 4; j++)
            run_job($urandom_range(1, 6), $urandom_range(1, 4), 4'($urandom),
                    16'($urandom), 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
